// File: rtl/dual_lane_pkg.sv
// Shared definitions for the two-lane serial link.
// Both ends use lane_pair so they agree on which lane carries the high bit.
package dual_lane_pkg;

    typedef enum logic {
        LANE_IDLE,
        LANE_SHIFT
    } lane_state_t;

    // Returns {data1, data2} for one bit pair under the given order.
    function automatic logic [1:0] lane_pair(
        input logic order,
        input logic hi,
        input logic lo
    );
        return order ? {lo, hi} : {hi, lo};
    endfunction

endpackage

// File: rtl/dual_lane_tx.sv
// Two-lane serial transmitter: one parallel word out as WORD_W/2 beats,
// LSB pair first, lane order chosen per word at accept.
module dual_lane_tx
    import dual_lane_pkg::*;
#(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_order,
    output logic              data1,
    output logic              data2,
    output logic              line_valid,
    output logic              frame
);

    localparam int NBEAT = WORD_W / 2;
    localparam int BW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;
    localparam logic [BW-1:0] LAST = BW'(NBEAT - 1);

    lane_state_t       state;
    logic [BW-1:0]     beat;
    logic [WORD_W-1:0] shreg;
    logic              order_q;
    logic              last;
    logic              accept;

    assign last     = (beat == LAST);
    assign in_ready = reset_n &&
                      (state == LANE_IDLE || (state == LANE_SHIFT && last));
    assign accept   = in_valid && in_ready;

    // Beat 0 is driven straight from in_data at accept; the shift
    // register only holds the pairs still to come.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= LANE_IDLE;
            beat       <= '0;
            shreg      <= '0;
            order_q    <= 1'b0;
            data1      <= 1'b0;
            data2      <= 1'b0;
            line_valid <= 1'b0;
            frame      <= 1'b0;
        end else if (accept) begin
            state          <= LANE_SHIFT;
            beat           <= '0;
            shreg          <= in_data >> 2;
            order_q        <= in_order;
            {data1, data2} <= lane_pair(in_order, in_data[1], in_data[0]);
            line_valid     <= 1'b1;
            frame          <= 1'b1;
        end else if (state == LANE_SHIFT && !last) begin
            beat           <= beat + 1'b1;
            shreg          <= shreg >> 2;
            {data1, data2} <= lane_pair(order_q, shreg[1], shreg[0]);
            frame          <= 1'b0;
        end else if (state == LANE_SHIFT) begin
            state      <= LANE_IDLE;
            beat       <= '0;
            shreg      <= '0;
            data1      <= 1'b0;
            data2      <= 1'b0;
            line_valid <= 1'b0;
            frame      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dual_lane_tx.sv
// Bench for dual_lane_tx at WORD_W=8 and WORD_W=2 against a queue-of-beats
// reference model, with directed cases followed by random traffic.
module tb_dual_lane_tx;

    logic       clk = 1'b0;
    logic       reset_n;

    logic       va, ra, oa, d1a, d2a, lva, fra;
    logic [7:0] da;
    logic       vb, rb, ob, d1b, d2b, lvb, frb;
    logic [1:0] db;

    int n_assert = 0;
    int n_fail   = 0;

    // Each entry: {data1, data2, frame}; head is the beat on the lanes.
    logic [2:0] qa[$];
    logic [2:0] qb[$];
    logic       acc_a, acc_b;

    always #5 clk = ~clk;

    dual_lane_tx #(.WORD_W(8)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .in_valid(va), .in_ready(ra), .in_data(da), .in_order(oa),
        .data1(d1a), .data2(d2a), .line_valid(lva), .frame(fra)
    );

    dual_lane_tx #(.WORD_W(2)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .in_valid(vb), .in_ready(rb), .in_data(db), .in_order(ob),
        .data1(d1b), .data2(d2b), .line_valid(lvb), .frame(frb)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(inout logic [2:0] q[$], input logic [7:0] w,
                             input int nbeat, input logic ord);
        for (int k = 0; k < nbeat; k++) begin
            logic hi, lo;
            hi = w[2*k+1];
            lo = w[2*k];
            q.push_back({ord ? lo : hi, ord ? hi : lo, k == 0});
        end
    endtask

    function automatic logic [3:0] exp_out(input logic [2:0] q[$]);
        if (q.size() == 0) return 4'b0000;
        return {1'b1, q[0][0], q[0][2], q[0][1]};
    endfunction

    task automatic check_outs();
        chk("outs_w8", {lva, fra, d1a, d2a}, exp_out(qa));
        chk("outs_w2", {lvb, frb, d1b, d2b}, exp_out(qb));
    endtask

    // One clock: check ready before the edge, advance model, check after.
    task automatic step();
        logic ea, eb;
        ea = reset_n && (qa.size() <= 1);
        eb = reset_n && (qb.size() <= 1);
        chk("ready_w8", ra, ea);
        chk("ready_w2", rb, eb);
        acc_a = va && ea;
        acc_b = vb && eb;
        @(posedge clk);
        if (qa.size() > 0) void'(qa.pop_front());
        if (qb.size() > 0) void'(qb.pop_front());
        if (acc_a) push_word(qa, da, 4, oa);
        if (acc_b) push_word(qb, {6'b0, db}, 1, ob);
        #1;
        check_outs();
    endtask

    task automatic send_a(input logic [7:0] w, input logic ord);
        va = 1'b1; da = w; oa = ord;
        step();
        va = 1'b0;
    endtask

    task automatic lanes_a(input string tag, input logic [7:0] exp8);
        // exp8 packs four (data1,data2) pairs, beat 0 in the top bits.
        logic [7:0] e;
        e = exp8;
        for (int k = 0; k < 4; k++) begin
            chk(tag, {d1a, d2a}, e[7-2*k -: 2]);
            if (k < 3) step();
        end
    endtask

    initial begin
        reset_n = 1'b0;
        va = 0; da = '0; oa = 0;
        vb = 0; db = '0; ob = 0;
        acc_a = 0; acc_b = 0;
        #2;
        check_outs();
        chk("ready_in_reset_w8", ra, 1'b0);
        chk("ready_in_reset_w2", rb, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("ready_after_release", ra, 1'b1);

        // B2 order 0, then order 1
        send_a(8'hB2, 1'b0);
        lanes_a("b2_order0", {2'b10, 2'b00, 2'b11, 2'b10});
        step();
        chk("idle_after_b2", lva, 1'b0);
        send_a(8'hB2, 1'b1);
        lanes_a("b2_order1", {2'b01, 2'b00, 2'b11, 2'b01});
        step();
        step();

        // Back-to-back FF then 00
        va = 1'b1; da = 8'hFF; oa = 1'b0;
        step();
        da = 8'h00;
        for (int i = 0; i < 4; i++) step();
        chk("b2b_second_accept", acc_a, 1'b1);
        va = 1'b0;
        for (int i = 0; i < 4; i++) step();

        // Held valid with order toggling every cycle
        va = 1'b1; da = 8'hC3; oa = 1'b1;
        step();
        da = 8'h3C;
        begin
            int n;
            n = 0;
            do begin
                oa = ~oa;
                step();
                n++;
            end while (!acc_a && n < 10);
            chk("held_accept_seen", acc_a, 1'b1);
        end
        va = 1'b0;
        step();
        step();

        // Reset in the middle of a word
        send_a(8'h96, 1'b0);
        step();
        step();
        reset_n = 1'b0;
        qa.delete();
        qb.delete();
        #1;
        check_outs();
        chk("ready_mid_reset", ra, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("ready_post_reset", ra, 1'b1);
        send_a(8'h5A, 1'b0);
        lanes_a("5a_after_reset", {2'b10, 2'b10, 2'b01, 2'b01});
        step();

        // WORD_W=2 stream
        vb = 1'b1; ob = 1'b0;
        db = 2'b10; step();
        chk("w2_beat0", {frb, d1b, d2b}, 3'b110);
        db = 2'b01; step();
        chk("w2_beat1", {frb, d1b, d2b}, 3'b101);
        db = 2'b11; step();
        chk("w2_beat2", {frb, d1b, d2b}, 3'b111);
        vb = 1'b0;
        step();

        // Random traffic on both instances
        for (int i = 0; i < 400; i++) begin
            if (acc_a || !va) begin
                va = ($urandom_range(0, 3) != 0);
                da = 8'($urandom);
            end
            oa = 1'($urandom);
            if (acc_b || !vb) begin
                vb = ($urandom_range(0, 3) != 0);
                db = 2'($urandom);
            end
            ob = 1'($urandom);
            step();
        end
        va = 0; vb = 0;
        for (int i = 0; i < 6; i++) step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dual_lane_tx.md
# dual_lane_tx

Two-lane serial transmitter: accepts a parallel word over a valid/ready handshake and drives it out two bits per cycle on lanes `data1`/`data2`, with a per-word `order` bit that selects which lane carries the high bit of each pair. It is the sending end of the two-lane capture registers in the receive path. Bit pairs go out LSB pair first, and the receiver reassembles them by applying the same `order`.

## Interface
- `WORD_W`, 8, word width in bits; must be even and ≥ 2; beats per word `NBEAT = WORD_W/2`
- `clk`  in  1  rising-edge clock, single domain
- `reset_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  `in_data`/`in_order` valid
- `in_ready`  out  1  block can accept a word this cycle
- `in_data`  in  WORD_W  word to send
- `in_order`  in  1  lane order for this word, sampled only at accept
- `data1`  out  1  lane 1 bit
- `data2`  out  1  lane 2 bit
- `line_valid`  out  1  lanes carry a valid beat
- `frame`  out  1  high on beat 0 of each word

## Operation
- Accept when `in_valid && in_ready` at a rising edge. Latch `in_data` into the shift register and `in_order` into the order register.
- States:
  - IDLE: no word in flight.
  - SHIFT: beats 0..NBEAT-1 in flight.
- State transitions:
  - IDLE → SHIFT on accept.
  - SHIFT → SHIFT on the last beat with an accept (back-to-back).
  - SHIFT → IDLE on the last beat without an accept.
- Beat k carries word bits `[2k+1:2k]`.
  - `order=0`: `data1 = bit 2k+1`, `data2 = bit 2k`.
  - `order=1`: `data1 = bit 2k`, `data2 = bit 2k+1`.
- `in_ready = reset_n && (state==IDLE || (state==SHIFT && beat==NBEAT-1))`. This is combinational from registered state.
- `in_order` and `in_data` changes after accept do not affect the word in flight.
- In IDLE: `data1=data2=line_valid=frame=0`.
- Beat counter width is `max(1, $clog2(NBEAT))`. It wraps from NBEAT-1 to 0 only on a back-to-back accept; otherwise it holds at 0 in IDLE.
- `WORD_W=2`: every word is one beat, and `frame` and `line_valid` are high together on that beat.

## Timing
- All outputs except `in_ready` are registered.
- Accept at edge N: beat 0 is visible on lanes from edge N until edge N+1, with `frame=1` and `line_valid=1`.
- Beat k is visible after edge N+k. The last beat is visible after edge N+NBEAT-1.
- Back-to-back words: beat 0 of the next word directly follows the last beat of the current word. There are no bubbles, so throughput is 2 bits/cycle.
- A word not accepted back-to-back gives one IDLE cycle with lanes at 0, `line_valid=0`, `frame=0`.
- Reset values (`reset_n` low, any time including mid-word):
  - state = IDLE
  - `data1`, `data2`, `line_valid`, `frame` = 0
  - beat counter = 0, shift and order registers = 0
  - `in_ready` = 0
- A word in flight during reset is discarded, and no partial beats follow.
- After `reset_n` rises, `in_ready=1` in the same cycle.
- `in_valid` held while busy: the block accepts the word only at the last-beat edge, and the word remains stable until then (upstream rule).

## Structure
- Shared package `dual_lane_pkg`:
  - state enum `lane_state_t {LANE_IDLE, LANE_SHIFT}`
  - function `lane_pair(order, hi, lo)` returning `{data1,data2}`, shared with the receive side so both ends use one ordering definition.
- Single module, no sub-module. The shift register, beat counter and state register live in one sequential process; `in_ready` is one continuous assignment.

## Test plan
- `WORD_W=8`, accept `8'hB2`, `order=0`. Lanes `(data1,data2)` over 4 beats: (1,0), (0,0), (1,1), (1,0). `frame` is high only on beat 0, `line_valid` is high for 4 cycles, then the block returns to IDLE.
- Same word, `order=1`: (0,1), (0,0), (1,1), (0,1).
- Back-to-back: `8'hFF` then `8'h00`, with `in_valid` held high. There are 8 consecutive `line_valid` cycles and `frame` pulses at beats 0 and 4. `in_ready` is high in the idle cycle before the first accept and on the last beat of `8'hFF`, and low on its beats 0–2.
- Held `in_valid` while busy with `in_order` toggling every cycle. The in-flight word keeps its latched order, and the second word uses the `in_order` value present at its accept edge.
- Assert `reset_n` low mid-word at beat 2. All outputs go to 0 immediately with no clock required. On release, `in_ready=1`, and a new word `8'h5A`, `order=0`, gives (1,0), (1,0), (0,1), (0,1).
- `WORD_W=2`: stream `2'b10`, `2'b01`, `2'b11` back-to-back with `order=0`. Lanes show (1,0), (0,1), (1,1), with `frame` high every cycle.
